slap_colour_mixer: RTL and testbench

//  Final video stage downstream of the foreground, background and sprite layers.

---
 rtl/slap_colour_mixer.sv | 165 ++++++++++++++++
 tb/tb_slap_colour_mixer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/slap_colour_mixer.sv
// Final video stage: layer priority, 256-entry RGB palette lookup and sync delay.
// Optional LAYER_MASK_EN adds a per-layer transparency mask input.
module slap_colour_mixer #(
  parameter int COLOUR_W    = 4,
  parameter bit FG_PRIORITY = 1'b1
) (
  input  logic                master_clk,
  input  logic                reset_n,
`ifdef LAYER_MASK_EN
  input  logic [2:0]          layer_mask,
`endif
  input  logic                pixel_ce,
  input  logic [7:0]          fg_pixel,
  input  logic [7:0]          sp_pixel,
  input  logic [7:0]          bg_pixel,
  input  logic                hblank_in,
  input  logic                vblank_in,
  input  logic                hsync_in,
  input  logic                vsync_in,
  input  logic [24:0]         dn_addr,
  input  logic [7:0]          dn_data,
  input  logic                dn_wr,
  input  logic                prom_r_cs,
  input  logic                prom_g_cs,
  input  logic                prom_b_cs,
  output logic [COLOUR_W-1:0] red,
  output logic [COLOUR_W-1:0] green,
  output logic [COLOUR_W-1:0] blue,
  output logic                hblank_out,
  output logic                vblank_out,
  output logic                hsync_out,
  output logic                vsync_out,
  output logic                palette_ready
);

  typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  got_reg, got_next;
  logic [2:0]  cs_vec;
  logic [2:0]  wr_en;
  logic        cs_one_hot;

  logic [7:0]  fg_s1, sp_s1, bg_s1;
  logic [3:0]  sync_s1;             // {hblank, vblank, hsync, vsync}
  logic [2:0]  mask_s1;
  logic [7:0]  idx;
  logic        fg_opaque, sp_opaque;
  logic [2:0][COLOUR_W-1:0] pal_rd;

  logic        unused_bits;
  assign unused_bits = ^{dn_addr[24:8], dn_data};

  // Writes are only accepted when exactly one colour PROM is selected.
  assign cs_vec     = {prom_b_cs, prom_g_cs, prom_r_cs};
  assign cs_one_hot = (cs_vec == 3'b001) || (cs_vec == 3'b010) || (cs_vec == 3'b100);
  assign wr_en      = (dn_wr && cs_one_hot) ? cs_vec : 3'b000;

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= EMPTY;
      got_reg   <= 3'b000;
    end else begin
      state_reg <= state_next;
      got_reg   <= got_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    got_next   = got_reg;
    if (dn_addr[7:0] == 8'hFF)
      got_next = got_reg | wr_en;
    case (state_reg)
      EMPTY:   if (|wr_en) state_next = LOADING;
      LOADING: if ((&got_reg) && (cs_vec == 3'b000)) begin
        state_next = READY;
        got_next   = 3'b000;
      end
      READY:   if (|wr_en) state_next = LOADING;
      default: state_next = EMPTY;
    endcase
  end

  assign palette_ready = (state_reg == READY);

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      fg_s1   <= 8'h00;
      sp_s1   <= 8'h00;
      bg_s1   <= 8'h00;
      sync_s1 <= 4'h0;
    end else if (pixel_ce) begin
      fg_s1   <= fg_pixel;
      sp_s1   <= sp_pixel;
      bg_s1   <= bg_pixel;
      sync_s1 <= {hblank_in, vblank_in, hsync_in, vsync_in};
    end
  end

`ifdef LAYER_MASK_EN
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n)
      mask_s1 <= 3'b000;
    else if (pixel_ce)
      mask_s1 <= layer_mask;
  end
`else
  assign mask_s1 = 3'b111;
`endif

  assign fg_opaque = (fg_s1[1:0] != 2'b00) && mask_s1[1];
  assign sp_opaque = (sp_s1[3:0] != 4'h0) && mask_s1[2];

  always_comb begin
    idx = mask_s1[0] ? bg_s1 : 8'h00;
    if (FG_PRIORITY) begin
      if (fg_opaque)      idx = fg_s1;
      else if (sp_opaque) idx = sp_s1;
    end else begin
      if (sp_opaque)      idx = sp_s1;
      else if (fg_opaque) idx = fg_s1;
    end
  end

  // One block RAM per channel; read is registered every clock so data is
  // ready well before the next pixel strobe.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [COLOUR_W-1:0] mem [256];
      logic [COLOUR_W-1:0] rd_q;
      always_ff @(posedge master_clk) begin
        if (wr_en[gi])
          mem[dn_addr[7:0]] <= dn_data[COLOUR_W-1:0];
        rd_q <= mem[idx];
      end
      assign pal_rd[gi] = rd_q;
    end
  endgenerate

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      hblank_out <= 1'b0;
      vblank_out <= 1'b0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
    end else if (pixel_ce) begin
      if (sync_s1[3] || sync_s1[2] || !palette_ready) begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end else begin
        red   <= pal_rd[0];
        green <= pal_rd[1];
        blue  <= pal_rd[2];
      end
      {hblank_out, vblank_out, hsync_out, vsync_out} <= sync_s1;
    end
  end

endmodule

// File: tb/tb_slap_colour_mixer.sv
// Directed bench for slap_colour_mixer: FG-priority and sprite-priority instances side by side.
module tb_slap_colour_mixer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pixel_ce;
  logic [7:0]  fg, sp, bg;
  logic        hb, vb, hs, vs;
  logic [24:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr, r_cs, g_cs, b_cs;
  logic [2:0]  mask;

  logic [3:0]  r1, g1, b1, r0, g0, b0;
  logic        hb1, vb1, hs1, vs1, rdy1;
  logic        hb0, vb0, hs0, vs0, rdy0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  slap_colour_mixer #(.COLOUR_W(4), .FG_PRIORITY(1'b1)) dut (
    .master_clk(clk), .reset_n(reset_n),
`ifdef LAYER_MASK_EN
    .layer_mask(mask),
`endif
    .pixel_ce(pixel_ce), .fg_pixel(fg), .sp_pixel(sp), .bg_pixel(bg),
    .hblank_in(hb), .vblank_in(vb), .hsync_in(hs), .vsync_in(vs),
    .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
    .prom_r_cs(r_cs), .prom_g_cs(g_cs), .prom_b_cs(b_cs),
    .red(r1), .green(g1), .blue(b1),
    .hblank_out(hb1), .vblank_out(vb1), .hsync_out(hs1), .vsync_out(vs1),
    .palette_ready(rdy1)
  );

  slap_colour_mixer #(.COLOUR_W(4), .FG_PRIORITY(1'b0)) dut0 (
    .master_clk(clk), .reset_n(reset_n),
`ifdef LAYER_MASK_EN
    .layer_mask(mask),
`endif
    .pixel_ce(pixel_ce), .fg_pixel(fg), .sp_pixel(sp), .bg_pixel(bg),
    .hblank_in(hb), .vblank_in(vb), .hsync_in(hs), .vsync_in(vs),
    .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr),
    .prom_r_cs(r_cs), .prom_g_cs(g_cs), .prom_b_cs(b_cs),
    .red(r0), .green(g0), .blue(b0),
    .hblank_out(hb0), .vblank_out(vb0), .hsync_out(hs0), .vsync_out(vs0),
    .palette_ready(rdy0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobe followed by three idle clocks.
  task automatic pixel();
    pixel_ce = 1'b1;
    tick();
    pixel_ce = 1'b0;
    repeat (3) tick();
  endtask

  task automatic set_px(input logic [7:0] f, input logic [7:0] s, input logic [7:0] b,
                        input logic h, input logic v, input logic hsy, input logic vsy);
    fg = f; sp = s; bg = b; hb = h; vb = v; hs = hsy; vs = vsy;
  endtask

  task automatic wr(input int ch, input logic [7:0] a, input logic [7:0] d);
    dn_addr = {17'd0, a};
    dn_data = d;
    r_cs = (ch == 0);
    g_cs = (ch == 1);
    b_cs = (ch == 2);
    dn_wr = 1'b1;
    tick();
    dn_wr = 1'b0;
    r_cs = 1'b0; g_cs = 1'b0; b_cs = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; pixel_ce = 1'b0; mask = 3'b111;
    set_px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    dn_addr = '0; dn_data = '0; dn_wr = 1'b0; r_cs = 1'b0; g_cs = 1'b0; b_cs = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {r1, g1, b1, hb1, vb1, hs1, vs1, rdy1}, 32'h0);
    reset_n = 1'b1;
    tick();

    // Full palette load: entry n = n[3:0] on every channel.
    for (int ch = 0; ch < 3; ch++)
      for (int a = 0; a < 256; a++) begin
        logic [7:0] av;
        av = 8'(a);
        wr(ch, av, {4'h0, av[3:0]});
      end
    check("ready_not_yet", rdy1, 1'b0);
    tick();
    check("ready_after_load", rdy1, 1'b1);
    check("ready_after_load_sp", rdy0, 1'b1);

    // Priority and two-strobe latency.
    set_px(8'h05, 8'h23, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    pixel();
    set_px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("latency_one_strobe", {r1, g1, b1}, 12'h000);
    pixel();
    check("fg_priority", {r1, g1, b1}, 12'h555);
    check("sp_priority", {r0, g0, b0}, 12'h333);

    // Transparent FG and SP fall through to BG; blanking forces black.
    set_px(8'h04, 8'h20, 8'h4A, 1'b0, 1'b0, 1'b0, 1'b0);
    pixel();
    set_px(8'h05, 8'h23, 8'h40, 1'b1, 1'b0, 1'b0, 1'b1);
    pixel();
    check("bg_fallthrough", {r1, g1, b1}, 12'hAAA);
    check("bg_fallthrough_sp", {r0, g0, b0}, 12'hAAA);
    check("hblank_not_yet", hb1, 1'b0);
    set_px(8'h05, 8'h23, 8'h40, 1'b0, 1'b1, 1'b1, 1'b0);
    pixel();
    check("hblank_black", {r1, g1, b1}, 12'h000);
    check("hblank_vsync_out", {hb1, vb1, hs1, vs1}, 4'b1001);
    set_px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    pixel();
    check("vblank_black", {r0, g0, b0}, 12'h000);
    check("vblank_hsync_out", {hb0, vb0, hs0, vs0}, 4'b0110);

    // Pipeline freezes while pixel_ce stays low.
    set_px(8'h04, 8'h20, 8'h4A, 1'b0, 1'b0, 1'b0, 1'b0);
    pixel();
    set_px(8'h05, 8'h23, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    pixel();
    check("pre_hold", {r1, g1, b1}, 12'hAAA);
    for (int i = 0; i < 10; i++) begin
      set_px(8'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom));
      tick();
    end
    check("hold_rgb", {r1, g1, b1}, 12'hAAA);
    check("hold_sync", {hb1, vb1, hs1, vs1}, 4'b0000);
    set_px(8'h00, 8'h07, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    pixel();
    check("resume_held_fg", {r1, g1, b1}, 12'h555);
    check("resume_held_sp", {r0, g0, b0}, 12'h333);
    set_px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    pixel();
    check("resume_new", {r1, g1, b1}, 12'h777);

    // Two PROM selects at once must be ignored.
    dn_addr = 25'h05; dn_data = 8'h09; r_cs = 1'b1; g_cs = 1'b1; dn_wr = 1'b1;
    tick();
    dn_wr = 1'b0; r_cs = 1'b0; g_cs = 1'b0;
    check("multi_cs_ready", rdy1, 1'b1);

    // Rewrite in READY drops ready and blacks out the picture.
    wr(1, 8'h10, 8'h07);
    check("rewrite_drops_ready", rdy1, 1'b0);
    set_px(8'h00, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    pixel();
    set_px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    pixel();
    check("not_ready_black", {r1, g1, b1}, 12'h000);
    wr(0, 8'hFF, 8'h0F);
    wr(1, 8'hFF, 8'h0F);
    wr(2, 8'hFF, 8'h0F);
    check("reload_not_yet", rdy1, 1'b0);
    tick();
    check("reload_ready", rdy1, 1'b1);
    set_px(8'h00, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    pixel();
    set_px(8'h05, 8'h23, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    pixel();
    check("green_only_entry", {r1, g1, b1}, 12'h070);
    set_px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    pixel();
    check("multi_cs_no_write", {r1, g1, b1}, 12'h555);

    // Asynchronous reset mid-load.
    wr(0, 8'hFF, 8'h0F);
    check("midload_not_ready", rdy1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_rgb", {r1, g1, b1}, 12'h000);
    check("async_reset_ready", rdy1, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    wr(1, 8'hFF, 8'h0F);
    wr(2, 8'hFF, 8'h0F);
    tick();
    check("got_r_cleared", rdy1, 1'b0);
    wr(0, 8'hFF, 8'h0F);
    tick();
    check("ready_after_reset_load", rdy1, 1'b1);
    set_px(8'h05, 8'h23, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    pixel();
    set_px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    pixel();
    check("palette_kept", {r1, g1, b1}, 12'h555);

`ifdef LAYER_MASK_EN
    mask = 3'b101;
    set_px(8'h05, 8'h23, 8'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    pixel();
    mask = 3'b011;
    set_px(8'h04, 8'h23, 8'h4A, 1'b0, 1'b0, 1'b0, 1'b0);
    pixel();
    check("mask_fg_off", {r1, g1, b1}, 12'h333);
    mask = 3'b111;
    set_px(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    pixel();
    check("mask_sp_off", {r0, g0, b0}, 12'hAAA);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
